// File: rtl/aes_round_linear.sv
// AES round linear layer: ShiftRows+MixColumns (or InvMixColumns+InvShiftRows)
// on a 128-bit state, computed combinationally and registered once.
module aes_round_linear (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         inverse,
  input  logic         skip_mix,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         out_valid
);

  // Byte k occupies data[127-8k -: 8]; row = k mod 4, column = k div 4.
  function automatic logic [7:0] get_byte(input logic [127:0] s, input int r, input int c);
    return s[127 - 8 * (4 * c + r) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant as a sum of b, 2b, 4b and 8b.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] coef);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    logic [7:0] acc;
    x2  = xtime(b);
    x4  = xtime(x2);
    x8  = xtime(x4);
    acc = 8'h00;
    if (coef[0]) acc = acc ^ b;
    if (coef[1]) acc = acc ^ x2;
    if (coef[2]) acc = acc ^ x4;
    if (coef[3]) acc = acc ^ x8;
    return acc;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int           src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        o[127 - 8 * (4 * c + r) -: 8] = get_byte(s, r, src);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [3:0]   coef [4];
    logic [7:0]   col  [4];
    logic [7:0]   acc;
    o = '0;
    if (inv) begin
      coef[0] = 4'he; coef[1] = 4'hb; coef[2] = 4'hd; coef[3] = 4'h9;
    end else begin
      coef[0] = 4'h2; coef[1] = 4'h3; coef[2] = 4'h1; coef[3] = 4'h1;
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) col[r] = get_byte(s, r, c);
      // Each output row uses the coefficient vector rotated by its row index.
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(col[(r + k) % 4], coef[k]);
        o[127 - 8 * (4 * c + r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  logic [127:0] stage;
  logic [127:0] result;

  always_comb begin
    stage  = '0;
    result = '0;
    if (inverse) begin
      stage  = skip_mix ? data_in : mix_columns(data_in, 1'b1);
      result = shift_rows(stage, 1'b1);
    end else begin
      stage  = shift_rows(data_in, 1'b0);
      result = skip_mix ? stage : mix_columns(stage, 1'b0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) data_out <= result;
    end
  end

endmodule

// File: tb/tb_aes_round_linear.sv
// Directed bench for aes_round_linear using FIPS-197 round vectors and
// well-known MixColumns column vectors.
module tb_aes_round_linear;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         inverse;
  logic         skip_mix;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         out_valid;

  int passed = 0;
  int total  = 0;

  aes_round_linear dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .inverse   (inverse),
    .skip_mix  (skip_mix),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_data(input string tag, input logic [127:0] exp);
    total++;
    assert (data_out === exp) passed++;
    else $error("FAIL %s data_out=%h expected=%h", tag, data_out, exp);
  endtask

  task automatic check_valid(input string tag, input logic exp);
    total++;
    assert (out_valid === exp) passed++;
    else $error("FAIL %s out_valid=%b expected=%b", tag, out_valid, exp);
  endtask

  // Drive one sample, clock it in, and sample outputs 1 time unit after the edge.
  task automatic step(input logic v, input logic inv, input logic skip, input logic [127:0] d);
    in_valid = v;
    inverse  = inv;
    skip_mix = skip;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] SubOut  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] SrOut   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] McOut   = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] ColA    = {4{32'hdb135345}};
  localparam logic [127:0] ColAMc  = {4{32'h8e4da1bc}};
  localparam logic [127:0] ColB    = {4{32'hf20a225c}};
  localparam logic [127:0] ColBMc  = {4{32'h9fdc589d}};
  localparam logic [127:0] ColC    = {4{32'hd4d4d4d5}};
  localparam logic [127:0] ColCMc  = {4{32'hd5d5d7d6}};
  localparam logic [127:0] ColD    = {4{32'h2d26314c}};
  localparam logic [127:0] ColDMc  = {4{32'h4d7ebdf8}};
  localparam logic [127:0] Flat    = {16{8'hc6}};

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    inverse  = 1'b0;
    skip_mix = 1'b0;
    data_in  = SubOut;
    repeat (2) @(posedge clk);
    #1;
    check_data("reset_data", 128'h0);
    check_valid("reset_valid", 1'b0);
    // Input valid during reset must not be captured.
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_valid("reset_hold_valid", 1'b0);
    check_data("reset_hold_data", 128'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 1'b0, 1'b0, SubOut);
    check_data("fwd_mix", McOut);
    check_valid("fwd_mix_valid", 1'b1);
    step(1'b1, 1'b0, 1'b1, SubOut);
    check_data("fwd_skip", SrOut);
    step(1'b1, 1'b1, 1'b0, McOut);
    check_data("inv_mix", SubOut);
    step(1'b1, 1'b1, 1'b1, SrOut);
    check_data("inv_skip", SubOut);

    step(1'b1, 1'b0, 1'b0, ColA);
    check_data("fwd_colA", ColAMc);
    step(1'b1, 1'b0, 1'b0, ColB);
    check_data("fwd_colB", ColBMc);
    step(1'b1, 1'b0, 1'b0, ColC);
    check_data("fwd_colC", ColCMc);
    step(1'b1, 1'b0, 1'b0, ColD);
    check_data("fwd_colD", ColDMc);
    step(1'b1, 1'b1, 1'b0, ColAMc);
    check_data("inv_colA", ColA);
    step(1'b1, 1'b1, 1'b0, ColDMc);
    check_data("inv_colD", ColD);
    step(1'b1, 1'b0, 1'b0, Flat);
    check_data("fwd_flat", Flat);
    step(1'b1, 1'b1, 1'b0, 128'h0);
    check_data("inv_zero", 128'h0);

    // Idle cycle: data held, valid low.
    step(1'b0, 1'b0, 1'b0, SubOut);
    check_valid("idle_valid", 1'b0);
    check_data("idle_hold", 128'h0);

    // Back-to-back alternating modes.
    step(1'b1, 1'b0, 1'b0, SubOut);
    check_data("b2b_0", McOut);
    check_valid("b2b_0_valid", 1'b1);
    step(1'b1, 1'b1, 1'b0, ColBMc);
    check_data("b2b_1", ColB);
    check_valid("b2b_1_valid", 1'b1);
    step(1'b1, 1'b0, 1'b1, SubOut);
    check_data("b2b_2", SrOut);
    check_valid("b2b_2_valid", 1'b1);
    step(1'b0, 1'b1, 1'b0, McOut);
    check_valid("b2b_end_valid", 1'b0);
    check_data("b2b_end_hold", SrOut);
    step(1'b0, 1'b0, 1'b0, ColA);
    check_data("b2b_end_hold2", SrOut);

    // Asynchronous reset while out_valid is high.
    step(1'b1, 1'b0, 1'b0, ColC);
    check_valid("pre_rst_valid", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_data("async_rst_data", 128'h0);
    check_valid("async_rst_valid", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b1, SrOut);
    check_data("post_rst", SubOut);
    check_valid("post_rst_valid", 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/aes_round_linear.md
# aes_round_linear

Registered AES linear-layer unit applying ShiftRows followed by MixColumns (or the inverse pair) to a 128-bit state in a single clock cycle. Sits in the AES round datapath between SubBytes and AddRoundKey. Forward mode transforms the SubBytes output; inverse mode undoes it for decryption. A skip-mix control serves the final round, which has no MixColumns.

## Interface
- No parameters; state width fixed at 128 bits.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  data_in qualifier; result is captured when high.
- inverse  input  1  0: forward (ShiftRows then MixColumns); 1: inverse (InvMixColumns then InvShiftRows).
- skip_mix  input  1  1: bypass the (Inv)MixColumns stage and apply only (Inv)ShiftRows.
- data_in  input  128  state in standard AES byte order.
- data_out  output  128  transformed state, same byte order.
- out_valid  output  1  high for one cycle after each accepted in_valid.

## Operation
- Byte k (0..15) = data[127-8k -: 8]. It maps to state row r = k mod 4, column c = k div 4 (column-major, FIPS-197 order).
- Internally the state is viewed as a 4x4 row/column array. Any internal transpose to row-major form is invisible at the ports.
- ShiftRows: s'[r][c] = s[r][(c+r) mod 4]. InvShiftRows: s'[r][c] = s[r][(c-r) mod 4]. Row 0 is unchanged.
- MixColumns, per column, in GF(2^8) with polynomial 0x11B:
  - out0 = 2a0^3a1^a2^a3; out1 = a0^2a1^3a2^a3; out2 = a0^a1^2a2^3a3; out3 = 3a0^a1^a2^2a3.
  - xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
- InvMixColumns uses coefficients {0E,0B,0D,09}, rotated per row in the same pattern.
- Forward: data_out = MC(SR(data_in)). Inverse: data_out = InvSR(InvMC(data_in)). The two are exact inverses.
- skip_mix=1: forward gives SR(data_in); inverse gives InvSR(data_in).
- The whole transform is combinational from data_in/inverse/skip_mix into a single 128-bit output register.

## Timing
- Reset (rst_n low, async): data_out = 0, out_valid = 0, held until rst_n rises. Deassertion takes effect at the next clock edge.
- Latency 1 cycle: when in_valid=1 at edge N, data_out and out_valid=1 are valid after edge N.
- in_valid=0 at an edge: data_out holds its previous value and out_valid=0.
- Throughput: one state per cycle. Back-to-back in_valid is fully supported with no stalls and no backpressure.
- inverse and skip_mix are sampled with data_in at the same edge. Changing them between cycles is legal; each sample uses its own mode.
- Reset asserted mid-stream clears both outputs immediately. The in-flight result is discarded.

## Test plan
- Forward: in_valid=1, inverse=0, skip_mix=0, data_in=d42711aee0bf98f1b8b45de51e415230 -> next cycle data_out=046681e5e0cb199a48f8d37a2806264c, out_valid=1.
- Forward, skip_mix=1, same data_in -> data_out=d4bf5d30e0b452aeb84111f11e2798e5.
- Inverse, skip_mix=0, data_in=046681e5e0cb199a48f8d37a2806264c -> data_out=d42711aee0bf98f1b8b45de51e415230.
- Inverse, skip_mix=1, data_in=d4bf5d30e0b452aeb84111f11e2798e5 -> data_out=d42711aee0bf98f1b8b45de51e415230.
- Back-to-back: three consecutive in_valid cycles alternating forward/inverse, then in_valid=0.
  - Each result appears one cycle later.
  - out_valid drops after the last result; data_out then holds the last result.
- Reset: assert rst_n=0 asynchronously while out_valid=1 -> data_out=0 and out_valid=0 immediately, without waiting for a clock edge.
